// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: function codes, FSM encoding
// and the add/sub signed-overflow helper.
package alu_pkg;

    localparam logic [2:0] FXN_PASS_A = 3'b000;
    localparam logic [2:0] FXN_PASS_B = 3'b001;
    localparam logic [2:0] FXN_ADD    = 3'b010;
    localparam logic [2:0] FXN_SUB    = 3'b011;
    localparam logic [2:0] FXN_AND    = 3'b100;
    localparam logic [2:0] FXN_OR     = 3'b101;
    localparam logic [2:0] FXN_MUL    = 3'b110;
    localparam logic [2:0] FXN_SHL    = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Subtraction is A + ~B + 1, so the effective B sign is inverted.
    function automatic logic add_sub_ovf(input logic a_msb, input logic b_msb,
                                         input logic r_msb, input logic is_sub);
        logic b_eff;
        b_eff = b_msb ^ is_sub;
        return (a_msb == b_eff) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle operations (pass, add, sub, and, or).
// Multiply and shift codes yield zeros here; the sequencer handles them.
module alu_core #(
    parameter int WIDTH = 6
) (
    input  logic [2:0]       fxn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             o_flow
);
    import alu_pkg::*;

    logic [WIDTH:0] sum_s;

    // Result and flags for the single-cycle function codes.
    always_comb begin
        result = '0;
        c_out  = 1'b0;
        o_flow = 1'b0;
        sum_s  = '0;
        case (fxn)
            FXN_PASS_A: result = a;
            FXN_PASS_B: result = b;
            FXN_ADD: begin
                sum_s  = {1'b0, a} + {1'b0, b};
                result = sum_s[WIDTH-1:0];
                c_out  = sum_s[WIDTH];
                o_flow = add_sub_ovf(a[WIDTH-1], b[WIDTH-1], sum_s[WIDTH-1], 1'b0);
            end
            FXN_SUB: begin
                // The extra MSB wraps to 1 exactly when A < B.
                sum_s  = {1'b0, a} - {1'b0, b};
                result = sum_s[WIDTH-1:0];
                c_out  = sum_s[WIDTH];
                o_flow = add_sub_ovf(a[WIDTH-1], b[WIDTH-1], sum_s[WIDTH-1], 1'b1);
            end
            FXN_AND: result = a & b;
            FXN_OR:  result = a | b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with start/busy/done handshake: owns the FSM, the step
// counter and the iterative shift-add multiply and shift-left datapaths.
module seq_alu #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       fxn,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    output logic [WIDTH-1:0] out,
    output logic             o_flow,
    output logic             c_out,
    output logic             busy,
    output logic             done
);
    import alu_pkg::*;

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] STEPS_MAX = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] SHIFT_CAP = WIDTH'(WIDTH);

    state_e               state_q, state_d;
    logic [2:0]           fxn_q, fxn_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d, acc_q, acc_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     shv_q, shv_d;
    logic                 shc_q, shc_d, shl_en_q, shl_en_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic                 o_flow_q, o_flow_d, c_out_q, c_out_d;

    logic [WIDTH-1:0]     core_res_s;
    logic                 core_c_s, core_v_s;
    logic [2*WIDTH-1:0]   acc_step_s;
    logic [WIDTH-1:0]     shv_step_s;
    logic                 shc_step_s;
    logic [CNT_W-1:0]     shamt_s, steps_s;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .fxn    (fxn_q),
        .a      (a_q),
        .b      (b_q),
        .result (core_res_s),
        .c_out  (core_c_s),
        .o_flow (core_v_s)
    );

    // Next-state, iteration step and result write-back.
    always_comb begin
        state_d  = state_q;
        fxn_d    = fxn_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        shv_d    = shv_q;
        shc_d    = shc_q;
        shl_en_d = shl_en_q;
        out_d    = out_q;
        o_flow_d = o_flow_q;
        c_out_d  = c_out_q;

        acc_step_s = acc_q + (mplier_q[0] ? mcand_q : '0);
        shv_step_s = shl_en_q ? {shv_q[WIDTH-2:0], 1'b0} : shv_q;
        shc_step_s = shl_en_q ? shv_q[WIDTH-1] : shc_q;

        shamt_s = (input_b >= SHIFT_CAP) ? STEPS_MAX : input_b[CNT_W-1:0];
        case (fxn)
            FXN_MUL: steps_s = STEPS_MAX;
            FXN_SHL: steps_s = (shamt_s == '0) ? CNT_W'(1) : shamt_s;
            default: steps_s = CNT_W'(1);
        endcase

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    fxn_d    = fxn;
                    a_d      = input_a;
                    b_d      = input_b;
                    cnt_d    = steps_s;
                    mcand_d  = {{WIDTH{1'b0}}, input_a};
                    mplier_d = input_b;
                    acc_d    = '0;
                    shv_d    = input_a;
                    shc_d    = 1'b0;
                    shl_en_d = (shamt_s != '0);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d    = acc_step_s;
                mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                shv_d    = shv_step_s;
                shc_d    = shc_step_s;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    case (fxn_q)
                        FXN_MUL: begin
                            out_d    = acc_step_s[WIDTH-1:0];
                            o_flow_d = |acc_step_s[2*WIDTH-1:WIDTH];
                            c_out_d  = 1'b0;
                        end
                        FXN_SHL: begin
                            out_d    = shv_step_s;
                            o_flow_d = 1'b0;
                            c_out_d  = shc_step_s;
                        end
                        default: begin
                            out_d    = core_res_s;
                            o_flow_d = core_v_s;
                            c_out_d  = core_c_s;
                        end
                    endcase
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            fxn_q    <= 3'b000;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            shv_q    <= '0;
            shc_q    <= 1'b0;
            shl_en_q <= 1'b0;
            out_q    <= '0;
            o_flow_q <= 1'b0;
            c_out_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            fxn_q    <= fxn_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            shv_q    <= shv_d;
            shc_q    <= shc_d;
            shl_en_q <= shl_en_d;
            out_q    <= out_d;
            o_flow_q <= o_flow_d;
            c_out_q  <= c_out_d;
        end
    end

    assign out    = out_q;
    assign o_flow = o_flow_q;
    assign c_out  = c_out_q;
    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);

endmodule
